uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares a single `uart_tx` serializer among `NUM_REQ` byte producers. It sits between the producers and `uart_tx`, and owns that instance's `i_start`/`i_data` inputs. It sequences one frame at a time: grant, single-cycle start, wait for completion, then re-arbitrate. A watchdog recovers if the serializer never reports completion.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
// FSM encoding and counter width helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request at or after
// the pointer, wrapping modulo NUM_REQ.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PW-1:0]      o_idx,
  output logic               o_valid
);

  int          w_j;
  logic [PW-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    w_pos   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_j = int'(i_ptr) + off;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      w_pos = PW'(w_j);
      if (!o_valid && i_req[w_pos]) begin
        o_valid        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ producers,
// with done edge detection and a saturating completion watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_sent,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_timeout,
  output logic                          o_tx_start,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  input  logic                          i_tx_busy,
  input  logic                          i_tx_done
);

  localparam int PW = idx_width(NUM_REQ);
  localparam int WW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PTR_TOP = PW'(NUM_REQ - 1);

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [WW-1:0] r_wd;
  logic          r_done_q;

  logic [NUM_REQ-1:0] w_win;
  logic [PW-1:0]      w_idx;
  logic               w_valid;
  logic               w_done_rise;

  assign w_done_rise = i_tx_done & ~r_done_q;

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .i_req  (i_req),
    .i_ptr  (r_ptr),
    .o_grant(w_win),
    .o_idx  (w_idx),
    .o_valid(w_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_wd       <= '0;
      r_done_q   <= 1'b0;
      o_ack      <= '0;
      o_sent     <= '0;
      o_grant    <= '0;
      o_timeout  <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      r_done_q   <= i_tx_done;
      o_ack      <= '0;
      o_sent     <= '0;
      o_timeout  <= 1'b0;
      o_tx_start <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          o_grant <= '0;
          if (w_valid && !i_tx_busy) begin
            o_grant    <= w_win;
            o_ack      <= w_win;
            o_tx_start <= 1'b1;
            o_tx_data  <=
              i_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
            r_ptr      <= (w_idx == PTR_TOP) ?
                          '0 : w_idx + 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          r_wd    <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // a done edge beats a coincident timeout
          if (w_done_rise) begin
            o_sent  <= o_grant;
            o_grant <= '0;
            r_state <= ST_IDLE;
          end else if (r_wd == WD_LAST) begin
            o_timeout <= 1'b1;
            o_grant   <= '0;
            r_state   <= ST_IDLE;
          end
          if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural
// serializer stub and a round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TMO = 64;
  localparam int STUCK_BUSY = 40;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic [N-1:0]    o_ack, o_sent, o_grant;
  logic            o_timeout, o_tx_start;
  logic [DW-1:0]   o_tx_data;

  logic stub_busy  = 1'b0;
  logic stub_done  = 1'b0;
  logic stub_stuck = 1'b0;
  logic force_done = 1'b0;
  int   stub_cnt   = 0;
  logic w_done;

  assign w_done = stub_done | force_done;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
    .o_ack(o_ack), .o_sent(o_sent), .o_grant(o_grant),
    .o_timeout(o_timeout), .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data), .i_tx_busy(stub_busy),
    .i_tx_done(w_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [7:0] byte_v;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  exp_t oc_q[$];
  int   mq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int model_ptr = 0;
  int lens[N];
  int last_start  = 0;
  int first_start = -1;
  int b2b_cyc     = -1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event expected none (cycle %0d)",
             name, cyc);
  endtask

  // serializer stub: len cycles busy, then a one-cycle done
  always @(posedge clk) begin
    int l;
    stub_done <= 1'b0;
    if (stub_busy) begin
      if (stub_cnt == 1) begin
        stub_busy <= 1'b0;
        stub_done <= !stub_stuck;
      end
      stub_cnt <= stub_cnt - 1;
    end else if (o_tx_start) begin
      l = (mq.size() > 0) ? mq.pop_front() : STUCK_BUSY;
      stub_busy  <= 1'b1;
      stub_stuck <= (l == 0);
      stub_cnt   <= (l == 0) ? STUCK_BUSY : l;
    end
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_ack != '0 && !o_tx_start) bad("ack_without_start");
        if (o_tx_start) begin
          if (exp_q.size() == 0) begin
            bad("unexpected_start");
          end else begin
            e = exp_q.pop_front();
            check("grant", o_grant, 64'(1) << e.idx);
            check("ack", o_ack, 64'(1) << e.idx);
            check("tx_data", o_tx_data, e.byte_v);
            oc_q.push_back(e);
            last_start = cyc;
            if (first_start >= 0)
              check("req_latency", cyc, first_start);
            else if (b2b_cyc >= 0)
              check("b2b_start", cyc, b2b_cyc);
            first_start = -1;
            b2b_cyc     = -1;
          end
        end
        if (o_sent != '0 || o_timeout) begin
          if (oc_q.size() == 0) begin
            bad("unexpected_completion");
          end else begin
            e = oc_q.pop_front();
            if (e.len == 0) begin
              check("timeout", o_timeout, 1);
              check("sent_on_timeout", o_sent, 0);
              check("timeout_latency", cyc - last_start,
                    TMO + 1);
            end else begin
              check("sent", o_sent, 64'(1) << e.idx);
              check("timeout_on_sent", o_timeout, 0);
              check("sent_latency", cyc - last_start,
                    e.len + 2);
            end
            check("grant_idle", o_grant, 0);
            if (exp_q.size() > 0) b2b_cyc = cyc + 1;
          end
        end
      end
    end
  end

  // requesters drop their request once acknowledged
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
        if (o_ack[k]) req[k] = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] mask,
                       input logic [N*DW-1:0] d);
    exp_t e;
    int   k;
    int   last;
    last = model_ptr;
    for (int off = 0; off < N; off++) begin
      k = (model_ptr + off) % N;
      if (mask[k]) begin
        e.idx    = k;
        e.byte_v = d[k*DW +: DW];
        e.len    = lens[k];
        exp_q.push_back(e);
        mq.push_back(lens[k]);
        last = k;
      end
    end
    model_ptr   = (last + 1) % N;
    first_start = cyc + 1;
    data = d;
    req  = req | mask;
  endtask

  task automatic set_lens(input int l);
    for (int k = 0; k < N; k++) lens[k] = l;
  endtask

  task automatic rand_lens();
    int r;
    for (int k = 0; k < N; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      lens[k] = 0;
      else if (r == 1) lens[k] = 63;
      else             lens[k] = int'($urandom_range(20, 45));
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 800; i++) begin
      if (exp_q.size() == 0 && oc_q.size() == 0 &&
          !stub_busy && o_grant == '0)
        return;
      tick();
    end
    check("idle_wait_expired", exp_q.size() + oc_q.size(), 0);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) return;
      tick();
    end
    check("start_wait_expired", exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, o_ack, 0);
    check({tag, "_sent"}, o_sent, 0);
    check({tag, "_grant"}, o_grant, 0);
    check({tag, "_timeout"}, o_timeout, 0);
    check({tag, "_tx_start"}, o_tx_start, 0);
    check({tag, "_tx_data"}, o_tx_data, 0);
  endtask

  initial begin
    int s;
    rst  = 1'b1;
    req  = '0;
    data = '0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    set_lens(40);
    issue(4'b0001, 32'h000000AB);
    wait_idle();

    set_lens(30);
    issue(4'b1111, 32'h13121110);
    wait_idle();
    issue(4'b1000, 32'h44000000);
    wait_idle();
    issue(4'b0110, 32'h00222100);
    wait_idle();

    force_done = 1'b1;
    repeat (2) tick();
    set_lens(40);
    issue(4'b0001, 32'h0000005A);
    wait_start();
    repeat (5) tick();
    force_done = 1'b0;
    wait_idle();

    set_lens(0);
    issue(4'b0001, 32'h000000C3);
    wait_idle();
    set_lens(63);
    issue(4'b0100, 32'h003C0000);
    wait_idle();

    for (int b = 0; b < 20; b++) begin
      rand_lens();
      issue(N'($urandom_range(1, (1 << N) - 1)),
            (N*DW)'($urandom));
      wait_idle();
      repeat (int'($urandom_range(0, 3))) tick();
    end

    set_lens(40);
    issue(4'b0001, 32'h00000096);
    wait_start();
    s = last_start;
    for (int i = 0; i < 100 && cyc < s + 12; i++) tick();
    rst = 1'b1;
    #1;
    check_zero("midreset");
    exp_q.delete();
    oc_q.delete();
    mq.delete();
    first_start = -1;
    b2b_cyc     = -1;
    model_ptr   = 0;
    req         = '0;
    repeat (2) tick();
    rst = 1'b0;
    set_lens(30);
    issue(4'b0010, 32'h00007700);
    first_start = s + 42;
    wait_idle();

    repeat (5) tick();
    check("final_queues_empty", exp_q.size() + oc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
